fdiv_sched: RTL and testbench

FDIV_SCHED -- requirements
Module: fdiv_sched

---
 rtl/fdiv_sched.sv | 145 ++++++++++++++
 tb/tb_fdiv_sched.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdiv_sched.sv
// Two-requester round-robin scheduler for a shared fixed-latency divider, with an in-order
// result FIFO. Define FDIV_SCHED_CHECK_EN to build the sticky div_out_valid protocol checker.
module fdiv_sched #(
  parameter int LAT   = 5,
  parameter int DEPTH = 8
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_x1,
  input  logic [31:0] req0_x2,
  input  logic [31:0] req1_x1,
  input  logic [31:0] req1_x2,
  output logic        div_valid,
  output logic [31:0] div_x1,
  output logic [31:0] div_x2,
  input  logic        div_out_valid,
  input  logic [31:0] div_y,
  input  logic        div_ovf,
  input  logic        div_unf,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_tag,
  output logic [31:0] res_y,
  output logic        res_ovf,
  output logic        res_unf,
  output logic        err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_S = (CW + 1)'(DEPTH);

  typedef struct packed {
    logic        tag;
    logic [31:0] y;
    logic        ovf;
    logic        unf;
  } res_entry_t;

  logic           rr;
  logic [CW-1:0]  inflight;
  logic [CW-1:0]  fifo_cnt;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [LAT-1:0] pipe_v;
  logic [LAT-1:0] pipe_tag;
  res_entry_t     mem [DEPTH];
  res_entry_t     head;

  logic credit;
  logic grant;
  logic sel;
  logic tail_v;
  logic push;
  logic pop;

  // Outstanding work (in the divider or waiting in the FIFO) never exceeds the FIFO size,
  // so a returning result always has a free slot.
  assign credit = ({1'b0, inflight} + {1'b0, fifo_cnt}) < DEPTH_S;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    grant = 1'b0;
    sel   = 1'b0;
    if (!rst && credit && (req0_valid || req1_valid)) begin
      grant = 1'b1;
      sel   = (req0_valid && req1_valid) ? rr : req1_valid;
    end
  end

  assign req0_ready = grant & ~sel;
  assign req1_ready = grant & sel;
  assign div_valid  = grant;
  assign div_x1     = grant ? (sel ? req1_x1 : req0_x1) : '0;
  assign div_x2     = grant ? (sel ? req1_x2 : req0_x2) : '0;

  assign tail_v = pipe_v[LAT-1];
  assign push   = div_out_valid & tail_v;
  assign pop    = res_valid & res_ready;

  always_ff @(posedge sys_clk) begin
    // NOTE: non-blocking assignments so every register samples its pre-edge value.
    if (rst) begin
      rr       <= 1'b0;
      inflight <= '0;
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pipe_v   <= '0;
    end else begin
      if (grant) rr <= ~sel;

      pipe_v[0] <= grant;
      for (int i = 1; i < LAT; i++) pipe_v[i] <= pipe_v[i-1];

      case ({grant, tail_v})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase

      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase

      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // NOTE: tag pipe and FIFO payload are not reset; the valid bits and counters qualify them.
  always_ff @(posedge sys_clk) begin
    pipe_tag[0] <= sel;
    for (int i = 1; i < LAT; i++) pipe_tag[i] <= pipe_tag[i-1];
    if (push) mem[wr_ptr] <= '{tag: pipe_tag[LAT-1], y: div_y, ovf: div_ovf, unf: div_unf};
  end

  assign head      = mem[rd_ptr];
  assign res_valid = (fifo_cnt != '0) & ~rst;
  assign res_tag   = res_valid & head.tag;
  assign res_y     = res_valid ? head.y : '0;
  assign res_ovf   = res_valid & head.ovf;
  assign res_unf   = res_valid & head.unf;

`ifdef FDIV_SCHED_CHECK_EN
  logic err_q;

  // A result strobe must coincide exactly with an issue reaching the end of the pipe.
  always_ff @(posedge sys_clk) begin
    if (rst)                          err_q <= 1'b0;
    else if (div_out_valid != tail_v) err_q <= 1'b1;
  end

  assign err = err_q & ~rst;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fdiv_sched.sv
// Self-checking bench for fdiv_sched: vector table, directed corner sequences and a random
// run, all compared against a queue-based reference model plus a fixed-latency divider model.
module tb_fdiv_sched;
  localparam int LAT   = 5;
  localparam int DEPTH = 8;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_x1, req0_x2, req1_x1, req1_x2;
  logic        div_valid;
  logic [31:0] div_x1, div_x2;
  logic        div_out_valid;
  logic [31:0] div_y;
  logic        div_ovf, div_unf;
  logic        res_valid, res_ready, res_tag;
  logic [31:0] res_y;
  logic        res_ovf, res_unf;
  logic        err;

  fdiv_sched #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .sys_clk(sys_clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_x1(req0_x1), .req0_x2(req0_x2), .req1_x1(req1_x1), .req1_x2(req1_x2),
    .div_valid(div_valid), .div_x1(div_x1), .div_x2(div_x2),
    .div_out_valid(div_out_valid), .div_y(div_y), .div_ovf(div_ovf), .div_unf(div_unf),
    .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag),
    .res_y(res_y), .res_ovf(res_ovf), .res_unf(res_unf), .err(err)
  );

  typedef struct { logic [31:0] x1; logic [31:0] x2; int due; } div_op_t;
  typedef struct { logic tag; int due; } track_t;
  typedef struct { logic tag; logic [31:0] y; logic ovf; logic unf; } res_t;
  typedef struct packed { logic [31:0] y; logic ovf; logic unf; } dres_t;
  typedef struct { logic v0; logic v1; logic rdy; logic e_r0; logic e_r1; } vec_t;

  div_op_t div_q[$];    // divider environment: issued ops awaiting their strobe
  track_t  track_q[$];  // model: issues the scheduler is still waiting on
  res_t    fifo_q[$];   // model: results queued for the consumer

  int   cyc, n_cmp, n_fail;
  logic m_rr, m_err, spur, dm_real;
  logic e_gnt, e_sel, e_pop, tail_now;

  function automatic dres_t div_model(input logic [31:0] a, input logic [31:0] b);
    dres_t r;
    if (a == 32'h40C0_0000 && b == 32'h4000_0000)
      r = '{y: 32'h4040_0000, ovf: 1'b0, unf: 1'b0};
    else
      r = '{y: a ^ {b[15:0], b[31:16]}, ovf: a[3] ^ b[7], unf: a[9] & b[2]};
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic rand_ops();
    req0_x1 = $urandom; req0_x2 = $urandom;
    req1_x1 = $urandom; req1_x2 = $urandom;
  endtask

  task automatic settle();
    dres_t r;
    dm_real = div_q.size() > 0 && div_q[0].due == cyc;
    if (spur) begin
      div_out_valid = 1'b1; div_y = 32'hDEAD_BEEF; div_ovf = 1'b1; div_unf = 1'b0;
    end else if (dm_real) begin
      r = div_model(div_q[0].x1, div_q[0].x2);
      div_out_valid = 1'b1; div_y = r.y; div_ovf = r.ovf; div_unf = r.unf;
    end else begin
      div_out_valid = 1'b0; div_y = '0; div_ovf = 1'b0; div_unf = 1'b0;
    end
    #1;
  endtask

  task automatic check_model();
    logic        e_rv;
    logic [31:0] ex1, ex2;
    res_t        h;
    e_gnt = !rst && (req0_valid || req1_valid) && (track_q.size() + fifo_q.size() < DEPTH);
    e_sel = (req0_valid && req1_valid) ? m_rr : req1_valid;
    ex1 = e_gnt ? (e_sel ? req1_x1 : req0_x1) : 32'h0;
    ex2 = e_gnt ? (e_sel ? req1_x2 : req0_x2) : 32'h0;
    check("req0_ready", req0_ready, e_gnt && !e_sel);
    check("req1_ready", req1_ready, e_gnt && e_sel);
    check("div_valid", div_valid, e_gnt);
    check("div_x1", div_x1, ex1);
    check("div_x2", div_x2, ex2);
    e_rv = !rst && fifo_q.size() > 0;
    check("res_valid", res_valid, e_rv);
    if (rst || e_rv) begin
      h = e_rv ? fifo_q[0] : '{tag: 1'b0, y: 32'h0, ovf: 1'b0, unf: 1'b0};
      check("res_tag", res_tag, h.tag);
      check("res_y", res_y, h.y);
      check("res_ovf", res_ovf, h.ovf);
      check("res_unf", res_unf, h.unf);
    end
    check("err", err, m_err && !rst);
    e_pop    = e_rv && res_ready;
    tail_now = track_q.size() > 0 && track_q[0].due == cyc;
  endtask

  task automatic advance();
    track_t t;
    @(posedge sys_clk);
    if (rst) begin
      track_q.delete();
      fifo_q.delete();
      m_rr  = 1'b0;
      m_err = 1'b0;
    end else begin
      if (e_pop) void'(fifo_q.pop_front());
      if (tail_now) begin
        t = track_q.pop_front();
        if (div_out_valid)
          fifo_q.push_back('{tag: t.tag, y: div_y, ovf: div_ovf, unf: div_unf});
      end
`ifdef FDIV_SCHED_CHECK_EN
      if (div_out_valid != tail_now) m_err = 1'b1;
`endif
      if (e_gnt) begin
        track_q.push_back('{tag: e_sel, due: cyc + LAT});
        m_rr = ~e_sel;
      end
    end
    if (dm_real) void'(div_q.pop_front());
    if (e_gnt)
      div_q.push_back('{x1: e_sel ? req1_x1 : req0_x1, x2: e_sel ? req1_x2 : req0_x2, due: cyc + LAT});
    cyc++;
    @(negedge sys_clk);
  endtask

  task automatic step();
    settle();
    check_model();
    advance();
  endtask

  // Requests and consumer are active during reset so the output gating is exercised.
  task automatic do_reset();
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
    rand_ops();
    step();
    step();
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  vec_t tbl[8];

  initial begin
    int   lat, cnt, g, seen;
    logic got_tag;
    logic [31:0] got_y;

    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    req0_x1 = '0; req0_x2 = '0; req1_x1 = '0; req1_x2 = '0;
    div_out_valid = 1'b0; div_y = '0; div_ovf = 1'b0; div_unf = 1'b0;
    spur = 1'b0; dm_real = 1'b0; cyc = 0; m_rr = 1'b0; m_err = 1'b0;
    n_cmp = 0; n_fail = 0;
    e_gnt = 1'b0; e_sel = 1'b0; e_pop = 1'b0; tail_now = 1'b0;

    tbl[0] = '{v0: 0, v1: 0, rdy: 1, e_r0: 0, e_r1: 0};
    tbl[1] = '{v0: 1, v1: 0, rdy: 1, e_r0: 1, e_r1: 0};
    tbl[2] = '{v0: 1, v1: 1, rdy: 1, e_r0: 0, e_r1: 1};
    tbl[3] = '{v0: 1, v1: 1, rdy: 1, e_r0: 1, e_r1: 0};
    tbl[4] = '{v0: 0, v1: 1, rdy: 0, e_r0: 0, e_r1: 1};
    tbl[5] = '{v0: 0, v1: 1, rdy: 1, e_r0: 0, e_r1: 1};
    tbl[6] = '{v0: 1, v1: 1, rdy: 1, e_r0: 1, e_r1: 0};
    tbl[7] = '{v0: 0, v1: 0, rdy: 1, e_r0: 0, e_r1: 0};

    #2;
    do_reset();

    // Vector table: arbitration from a fresh reset (rr = 0, plenty of credit)
    for (int i = 0; i < 8; i++) begin
      req0_valid = tbl[i].v0; req1_valid = tbl[i].v1; res_ready = tbl[i].rdy;
      rand_ops();
      settle();
      check_model();
      check("tbl_r0", req0_ready, tbl[i].e_r0);
      check("tbl_r1", req1_ready, tbl[i].e_r1);
      advance();
    end
    res_ready = 1'b1;
    idle(LAT + 8);

    // Single op: result visible LAT+1 cycles after issue
    do_reset();
    req0_valid = 1'b1; req0_x1 = 32'h40C0_0000; req0_x2 = 32'h4000_0000;
    settle();
    check_model();
    check("single_grant", req0_ready, 1'b1);
    advance();
    req0_valid = 1'b0; res_ready = 1'b0;
    lat = -1; got_tag = 1'b1; got_y = '0;
    for (int k = 1; k <= 20; k++) begin
      settle();
      check_model();
      if (res_valid && lat < 0) begin
        lat = k; got_tag = res_tag; got_y = res_y;
      end
      advance();
    end
    check("single_latency", lat, LAT + 1);
    check("single_tag", got_tag, 1'b0);
    check("single_y", got_y, 32'h4040_0000);
    res_ready = 1'b1;
    idle(2);

    // Contention: alternate grants starting with requester 0
    do_reset();
    res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      rand_ops();
      settle();
      check_model();
      g = req1_ready ? 1 : (req0_ready ? 0 : -1);
      check("contend_grant", g, i % 2);
      advance();
    end
    idle(LAT + 8);

    // Backpressure: exactly DEPTH accepts, then one more per pop
    do_reset();
    res_ready = 1'b0; req0_valid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      rand_ops();
      settle(); check_model();
      if (req0_ready) cnt++;
      advance();
    end
    check("bp_accepts", cnt, DEPTH);
    cnt = 0;
    res_ready = 1'b1;
    settle(); check_model();
    if (req0_ready) cnt++;
    advance();
    res_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rand_ops();
      settle(); check_model();
      if (req0_ready) cnt++;
      advance();
    end
    check("bp_after_pop", cnt, 1);

    // From a full FIFO: continuous pop with refill, pushes and pops overlapping
    res_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      rand_ops();
      step();
    end
    idle(LAT + DEPTH + 4);

    // Reset mid-flight: late divider strobes must be dropped
    do_reset();
    res_ready = 1'b1; req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin rand_ops(); step(); end
    req0_valid = 1'b0;
    step();
    rst = 1'b1; step(); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      settle(); check_model();
      if (res_valid) seen++;
      advance();
    end
    check("flush_res_valid", seen, 0);
`ifndef FDIV_SCHED_CHECK_EN
    check("flush_err", err, 1'b0);
`endif

    // Spurious divider strobe with an empty pipe
    idle(LAT + 2);
    do_reset();
    idle(2);
    spur = 1'b1; step(); spur = 1'b0;
    settle(); check_model();
`ifdef FDIV_SCHED_CHECK_EN
    check("spur_err_set", err, 1'b1);
`else
    check("spur_err_off", err, 1'b0);
`endif
    advance();
    idle(4);
    settle(); check_model();
`ifdef FDIV_SCHED_CHECK_EN
    check("spur_err_held", err, 1'b1);
`else
    check("spur_err_held_off", err, 1'b0);
`endif
    advance();
    do_reset();
    settle(); check_model();
    check("spur_err_cleared", err, 1'b0);
    advance();

    // Random traffic with occasional reset
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      req0_valid = $urandom_range(0, 2) != 0;
      req1_valid = $urandom_range(0, 2) != 0;
      res_ready  = $urandom_range(0, 3) != 0;
      rand_ops();
      step();
    end
    rst = 1'b0; res_ready = 1'b1;
    idle(LAT + DEPTH + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
